// File: rtl/mips_alu_if.sv
// ============================================================================
//  Module      : mips_alu_if
//  Description : Operand/control and result bus of the MIPS ALU, with the
//                valid qualifier on each direction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] ALUResult;
    logic             zero;
    logic             overflow;
    logic             out_valid;

    modport master (
        output in_valid, SrcA, SrcB, ALUControl,
        input  ALUResult, zero, overflow, out_valid
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ALUControl,
        output ALUResult, zero, overflow, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/mips_alu.sv
// ============================================================================
//  Module      : mips_alu
//  Description : 32-bit MIPS ALU (AND/OR/ADD/SUB/SLT and complemented-B logic
//                ops) with a single registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_alu #(
    parameter int WIDTH = 32
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    mips_alu_if.slave  bus
);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_ANDN = 3'b100;
    localparam logic [2:0] c_OP_ORN  = 3'b101;
    localparam logic [2:0] c_OP_SUB  = 3'b110;
    localparam logic [2:0] c_OP_SLT  = 3'b111;

    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_b_inv;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_lt;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;

    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_valid;

    assign w_a     = bus.SrcA;
    assign w_b     = bus.SrcB;
    assign w_b_inv = ~w_b;
    assign w_sum   = w_a + w_b;
    assign w_diff  = w_a + w_b_inv + c_ONE;

    assign w_add_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1]  != w_a[WIDTH-1]);
    assign w_sub_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
    // Sign of the difference corrected by overflow gives the true signed compare.
    assign w_lt      = w_diff[WIDTH-1] ^ w_sub_ovf;

    always_comb begin
        w_result = c_ZERO;
        w_ovf    = 1'b0;
        case (bus.ALUControl)
            c_OP_AND:  w_result = w_a & w_b;
            c_OP_OR:   w_result = w_a | w_b;
            c_OP_ADD: begin
                w_result = w_sum;
                w_ovf    = w_add_ovf;
            end
            c_OP_ANDN: w_result = w_a & w_b_inv;
            c_OP_ORN:  w_result = w_a | w_b_inv;
            c_OP_SUB: begin
                w_result = w_diff;
                w_ovf    = w_sub_ovf;
            end
            c_OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
            default:   w_result = c_ZERO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= c_ZERO;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_result <= w_result;
                r_ovf    <= w_ovf;
            end
        end
    end

    // Derived from the held result so it can never disagree with ALUResult.
    assign bus.zero      = (r_result == c_ZERO);
    assign bus.ALUResult = r_result;
    assign bus.overflow  = r_ovf;
    assign bus.out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mips_alu.sv
// ============================================================================
//  Module      : tb_mips_alu
//  Description : Self-checking bench for mips_alu with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_alu;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mips_alu_if #(.WIDTH(32)) bus ();

    mips_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: what the outputs must show after each edge.
    logic [31:0] m_res   = 32'h0;
    bit          m_ovf   = 1'b0;
    bit          m_valid = 1'b0;

    function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output bit ov);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint t;
        r  = 32'h0;
        ov = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                t  = sa + sb;
                r  = t[31:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd4: r = a & ~b;
            3'd5: r = a | ~b;
            3'd6: begin
                t  = sa - sb;
                r  = t[31:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd7: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res   = 32'h0;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            m_valid = bus.in_valid;
            if (bus.in_valid)
                model_op(bus.ALUControl, bus.SrcA, bus.SrcB, m_res, m_ovf);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle out of reset the DUT must track the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model.out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("model.ALUResult", bus.ALUResult, m_res);
            chk("model.zero",      32'(bus.zero), 32'(m_res == 32'h0));
            chk("model.overflow",  32'(bus.overflow), 32'(m_ovf));
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b1;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.SrcA       = 32'hDEAD_BEEF;
        bus.SrcB       = 32'h1234_5678;
        bus.ALUControl = 3'd2;
    endtask

    task automatic expect_out(input string name, input bit v, input logic [31:0] r,
                              input bit z, input bit ov);
        @(negedge clk);
        #1;
        chk({name, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({name, ".result"}, bus.ALUResult, r);
        chk({name, ".zero"}, 32'(bus.zero), 32'(z));
        chk({name, ".ovf"}, 32'(bus.overflow), 32'(ov));
    endtask

    task automatic single(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input bit z, input bit ov);
        drive(op, a, b);
        idle();
        expect_out(name, 1'b1, r, z, ov);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.SrcA       = 32'h0;
        bus.SrcB       = 32'h0;
        bus.ALUControl = 3'd0;

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst.valid",  32'(bus.out_valid), 32'd0);
        chk("rst.result", bus.ALUResult, 32'h0);
        chk("rst.zero",   32'(bus.zero), 32'd1);
        chk("rst.ovf",    32'(bus.overflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        single("add",     3'b010, 32'h0,        32'h7,        32'h7,        1'b0, 1'b0);
        single("and",     3'b000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0);
        single("or",      3'b001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0);
        single("andn",    3'b100, 32'h7,        32'h7,        32'h0,        1'b1, 1'b0);
        single("orn",     3'b101, 32'h0,        32'hFFFFFFF0, 32'h0000000F, 1'b0, 1'b0);
        single("rsvd",    3'b011, 32'h5,        32'h9,        32'h0,        1'b1, 1'b0);
        single("sub",     3'b110, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1'b0);
        single("slt_m1",  3'b111, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0);
        single("slt_p1",  3'b111, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
        single("slt_min", 3'b111, 32'h80000000, 32'h1,        32'h1,        1'b0, 1'b0);
        single("add_ovf", 3'b010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1);
        single("add_wrp", 3'b010, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0);
        single("sub_ovf", 3'b110, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1);

        // Three back-to-back ops, then a bubble holding the last result.
        drive(3'b010, 32'd10, 32'd20);
        drive(3'b110, 32'd3,  32'd3);
        expect_out("s1", 1'b1, 32'd30, 1'b0, 1'b0);
        drive(3'b001, 32'hA0, 32'h0B);
        expect_out("s2", 1'b1, 32'd0, 1'b1, 1'b0);
        idle();
        expect_out("s3", 1'b1, 32'hAB, 1'b0, 1'b0);
        expect_out("s_hold", 1'b0, 32'hAB, 1'b0, 1'b0);

        // Reset while a result is showing.
        drive(3'b010, 32'h7FFFFFFF, 32'h7FFFFFFF);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst2.valid",  32'(bus.out_valid), 32'd0);
        chk("rst2.result", bus.ALUResult, 32'h0);
        chk("rst2.zero",   32'(bus.zero), 32'd1);
        chk("rst2.ovf",    32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_out("post_rst", 1'b0, 32'h0, 1'b1, 1'b0);

        // Reset before a pending op is captured: it must never emerge.
        drive(3'b101, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_out("pend_a", 1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("pend_b", 1'b0, 32'h0, 1'b1, 1'b0);

        single("final", 3'b110, 32'd100, 32'd1, 32'd99, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit ALU for the single-cycle MIPS datapath, computing AND/OR/ADD/SUB/SLT and the complemented-B logic ops selected by a 3-bit ALUControl.
- Result and flags are registered once on the output: one-cycle latency, with an in_valid/out_valid qualifier.
- The zero flag feeds branch (beq) resolution; ALUResult feeds the data-memory address and register writeback paths.

Parameters:
- WIDTH, 32, datapath width of operands and result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and control are valid this cycle
- SrcA  input  WIDTH  operand A
- SrcB  input  WIDTH  operand B
- ALUControl  input  3  operation select
- ALUResult  output  WIDTH  registered result
- zero  output  1  registered; 1 when ALUResult == 0
- overflow  output  1  registered signed overflow (ADD/SUB only)
- out_valid  output  1  registered; ALUResult/zero/overflow are valid

Behaviour:
- Reset: rst_n low asynchronously forces ALUResult=0, zero=1, overflow=0, out_valid=0. Registers stay there while rst_n is low; normal operation starts at the first rising edge after rst_n goes high.
- Operation encoding (combinational, on SrcA/SrcB):
  - 000: A & B
  - 001: A | B
  - 010: A + B
  - 011: reserved; result 0
  - 100: A & ~B
  - 101: A | ~B
  - 110: A - B
  - 111: SLT, signed: result = {31'b0, lt}, where lt = sign(A-B) XOR signed-overflow(A-B)
- Arithmetic:
  - Two's complement, WIDTH bits; carry-out is discarded and wraps modulo 2^WIDTH.
  - Subtraction is implemented as A + ~B + 1.
- Overflow:
  - ADD: operands have the same sign and the sum sign differs.
  - SUB: operands have different signs and the result sign differs from A.
  - All other ops, including SLT, report 0.
- Zero: computed from the registered result value, so it is always consistent with ALUResult.
- Timing:
  - On a rising clk edge with in_valid=1, the result and flags for that cycle's inputs are captured, and out_valid=1 in the following cycle (latency 1).
  - Back-to-back in_valid gives one result per cycle.
- in_valid=0 at an edge: ALUResult/zero/overflow hold their previous values; out_valid goes 0.
- Reset asserted mid-operation: the pending result is discarded and outputs go to their reset values immediately; no result emerges after deassertion until a new in_valid.
- Input changes between edges have no effect on the outputs; only values sampled at the edge matter.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> ALUResult=0, zero=1, overflow=0, out_valid=0 without waiting for a clock edge.
- ADD: ALUControl=010, SrcA=0, SrcB=7, in_valid=1 -> next cycle ALUResult=7, zero=0, overflow=0, out_valid=1.
- AND-NOT: ALUControl=100, SrcA=7, SrcB=7 -> ALUResult=0, zero=1. Then OR-NOT 101 with A=0, B=FFFFFFF0 -> ALUResult=0000000F.
- SUB/SLT:
  - 110 with A=5, B=7 -> ALUResult=FFFFFFFE.
  - 111 with A=FFFFFFFF, B=1 -> 1.
  - 111 with A=1, B=FFFFFFFF -> 0.
  - 111 with A=80000000, B=1 -> 1, despite subtraction overflow.
- Overflow/wrap:
  - 010 with 7FFFFFFF+1 -> 80000000, overflow=1.
  - 010 with FFFFFFFF+1 -> 0, zero=1, overflow=0.
  - 110 with 80000000-1 -> 7FFFFFFF, overflow=1.
- Handshake: stream 3 ops on consecutive cycles, then in_valid=0 -> three consecutive out_valid pulses with matching results, then out_valid=0 with the last result held. Reset asserted between ops -> outputs cleared and no stale result after release.
